// File: rtl/spi_main_node.sv
// spi_main_node: serial initiator for the encryption unit's subnode port.
// Shifts a latched key and message block out MSB-first on mosi under cs_enc,
// waits for data_done (bounded by TIMEOUT), then shifts the cipher block back
// in from miso and presents it on result with a one-cycle done pulse.
module spi_main_node #(
    parameter int nk      = 8,
    parameter int nb      = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [32*nk-1:0]  key_in,
    input  logic [32*nb-1:0]  msg_in,
    output logic              mosi,
    output logic              cs_enc,
    input  logic              miso,
    input  logic              data_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [32*nb-1:0]  result
);

    localparam int KEY_BITS   = 32 * nk;
    localparam int MSG_BITS   = 32 * nb;
    localparam int FRAME_BITS = KEY_BITS + MSG_BITS;
    localparam int CNT_W      = $clog2(KEY_BITS);
    localparam int TMO_W      = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SEND_KEY,
        SEND_MSG,
        WAIT_DONE,
        RECV,
        FINISH
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [FRAME_BITS-1:0]   tx_shift;
    logic [MSG_BITS-1:0]     rx_shift;
    logic [CNT_W-1:0]        bit_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    timed_out;

    // State register.
    // NOTE: every clocked assignment uses <= so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs.
    // NOTE: every output and state_nxt gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        cs_enc    = 1'b1;
        mosi      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SEND_KEY;
            end
            SEND_KEY: begin
                cs_enc = 1'b0;
                busy   = 1'b1;
                mosi   = tx_shift[FRAME_BITS-1];
                if (bit_cnt == KEY_LAST) state_nxt = SEND_MSG;
            end
            SEND_MSG: begin
                cs_enc = 1'b0;
                busy   = 1'b1;
                mosi   = tx_shift[FRAME_BITS-1];
                if (bit_cnt == MSG_LAST) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                cs_enc = 1'b0;
                busy   = 1'b1;
                if (data_done) begin
                    state_nxt = RECV;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = FINISH;
                end
            end
            RECV: begin
                cs_enc = 1'b0;
                busy   = 1'b1;
                if (bit_cnt == MSG_LAST) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                err       = timed_out;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter, timeout counter, error flag and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt   <= '0;
                        timed_out <= 1'b0;
                    end
                end
                SEND_KEY: begin
                    bit_cnt <= (bit_cnt == KEY_LAST) ? '0 : bit_cnt + CNT_W'(1);
                    tmo_cnt <= '0;
                end
                SEND_MSG: begin
                    bit_cnt <= (bit_cnt == MSG_LAST) ? '0 : bit_cnt + CNT_W'(1);
                    tmo_cnt <= '0;
                end
                WAIT_DONE: begin
                    if (data_done) begin
                        bit_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timed_out <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RECV: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    // Load result on the final sample edge so it is already
                    // valid in the FINISH cycle alongside done.
                    if (bit_cnt == MSG_LAST) result <= {rx_shift[MSG_BITS-2:0], miso};
                end
                default: ;
            endcase
        end
    end

    // Transmit and receive shift registers.
    // NOTE: no reset here; tx_shift is loaded on every accepted start and rx_shift is only observed via result.
    always_ff @(posedge clk) begin
        case (state)
            IDLE:               if (start) tx_shift <= {key_in, msg_in};
            SEND_KEY, SEND_MSG: tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            RECV:               rx_shift <= {rx_shift[MSG_BITS-2:0], miso};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_main_node.sv
// tb_spi_main_node: drives spi_main_node against a behavioural AES-256 subnode
// and checks results, latency, timeout, start filtering and reset abort.
module tb_spi_main_node;

    localparam int NK     = 8;
    localparam int NB     = 4;
    localparam int TMO    = 16;
    localparam int KW     = 32 * NK;
    localparam int MW     = 32 * NB;
    localparam int FRAME  = KW + MW;
    localparam int BUDGET = 700;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] key_in;
    logic [MW-1:0] msg_in;
    logic          mosi;
    logic          cs_enc;
    logic          miso;
    logic          data_done;
    logic          busy;
    logic          done;
    logic          err;
    logic [MW-1:0] result;

    spi_main_node #(.nk(NK), .nb(NB), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .msg_in    (msg_in),
        .mosi      (mosi),
        .cs_enc    (cs_enc),
        .miso      (miso),
        .data_done (data_done),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [KW-1:0] key;
        logic [MW-1:0] msg;
        logic [MW-1:0] cipher;
        logic          err;
        int            lat;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad   = 0;
    int            sub_wait   = 0;
    bit            sub_silent = 1'b0;
    logic [KW-1:0] cap_key;
    logic [MW-1:0] cap_msg;
    int            cap_cnt = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference AES-256 ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin  // r = x^254, the GF(2^8) inverse
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    function automatic logic [127:0] aes256(input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w [0:59];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xtime(rc);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rnd = 0; rnd <= 14; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
                for (int col = 0; col < 4; col++)
                    for (int row = 0; row < 4; row++)
                        t[4*col+row] = s[4*((col+row)%4)+row];
                for (int i = 0; i < 16; i++) s[i] = t[i];
                if (rnd < 14) begin
                    for (int col = 0; col < 4; col++) begin
                        a0 = s[4*col];   a1 = s[4*col+1];
                        a2 = s[4*col+2]; a3 = s[4*col+3];
                        s[4*col]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                        s[4*col+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                        s[4*col+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                        s[4*col+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                    end
                end
            end
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    s[4*col+row] = s[4*col+row] ^ w[4*rnd+col][31-8*row -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // ---------------- behavioural subnode ----------------
    logic [FRAME-1:0] cap;
    logic [MW-1:0]    reply;
    bit               cap_ok;

    initial begin : subnode
        data_done = 1'b0;
        miso      = 1'b0;
        forever begin
            @(negedge clk);
            if (cs_enc === 1'b0) begin
                cap_ok = 1'b1;
                cap    = '0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge clk);
                    if (cs_enc !== 1'b0) begin
                        cap_ok = 1'b0;
                        break;
                    end
                    cap = {cap[FRAME-2:0], mosi};
                end
                if (cap_ok) begin
                    cap_key = cap[FRAME-1 -: KW];
                    cap_msg = cap[MW-1:0];
                    cap_cnt++;
                    if (!sub_silent) begin
                        reply = aes256(cap_key, cap_msg);
                        repeat (sub_wait) @(negedge clk);
                        data_done = 1'b1;
                        if (sub_wait == 0) @(negedge clk);
                        @(negedge clk);
                        data_done = 1'b0;
                        for (int i = MW - 1; i >= 0; i--) begin
                            miso = reply[i];
                            @(negedge clk);
                        end
                        miso = 1'b0;
                    end
                end
                while (cs_enc === 1'b0) @(negedge clk);
            end
        end
    end

    // ---------------- transaction driver ----------------
    task automatic run_txn(input logic [KW-1:0] k, input logic [MW-1:0] m,
                           input logic [MW-1:0] exp_c, input logic exp_err,
                           input int w, input bit silent, input bit inject);
        exp_t e;
        int   lat;
        int   cap_before;
        sub_wait   = w;
        sub_silent = silent;
        e.key    = k;
        e.msg    = m;
        e.cipher = exp_c;
        e.err    = exp_err;
        e.lat    = silent ? FRAME + TMO + 2 : FRAME + MW + 1 + ((w < 1) ? 1 : w);
        cap_before = cap_cnt;
        @(negedge clk);
        key_in = k;
        msg_in = m;
        start  = 1'b1;
        sb_q.push_back(e);
        lat = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                check("cs_first", cs_enc, 1'b0);
                check("busy_first", busy, 1'b1);
                check("mosi_first", mosi, k[KW-1]);
            end
            if (inject) begin
                if (c == 50) begin
                    key_in = ~k;
                    msg_in = ~m;
                end
                if (c == 300 || c == 450) start = 1'b1;
                if (c == 301 || c == 451) start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            check("done_seen", done, 1'b1);
        end else begin
            e = sb_q.pop_front();
            check("latency", lat, e.lat);
            check("result", result, e.cipher);
            check("err", err, e.err);
            check("cs_at_done", cs_enc, 1'b1);
            check("busy_at_done", busy, 1'b0);
            check("frames", cap_cnt - cap_before, 1);
            check("cap_key", cap_key, e.key);
            check("cap_msg", cap_msg, e.msg);
            if (inject) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_at_done", busy, 1'b0);
                check("result_held", result, e.cipher);
                key_in = k;
                msg_in = m;
            end
        end
        start = 1'b0;
    endtask

    task automatic rst_abort(input logic [KW-1:0] k, input logic [MW-1:0] m);
        exp_t e;
        int   seen;
        sub_wait   = 0;
        sub_silent = 1'b0;
        e.key    = k;
        e.msg    = m;
        e.cipher = '0;
        e.err    = 1'b0;
        e.lat    = 0;
        @(negedge clk);
        key_in = k;
        msg_in = m;
        start  = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cs", cs_enc, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        e = sb_q.pop_front();  // aborted request never completes
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("no_done_after_rst", seen, 0);
        check("rst_result", result, '0);
    endtask

    logic [KW-1:0] k1;
    logic [MW-1:0] m1, m2, c1, c2;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        msg_in = '0;
        repeat (3) @(negedge clk);
        check("reset_cs", cs_enc, 1'b1);
        check("reset_mosi", mosi, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_result", result, '0);
        rst = 1'b0;

        k1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        m1 = 128'h00112233445566778899aabbccddeeff;
        m2 = 128'hffeeddccbbaa99887766554433221100;
        c1 = 128'h8ea2b7ca516745bfeafc49904b496089;
        c2 = aes256(k1, m2);

        run_txn(k1, m1, c1, 1'b0, 0, 1'b0, 1'b1);  // known vector, minimum latency, stray starts
        run_txn(k1, m1, c1, 1'b0, 3, 1'b0, 1'b0);  // delayed data_done
        run_txn(k1, m2, c2, 1'b0, 0, 1'b0, 1'b0);  // back-to-back second vector
        run_txn(k1, m1, c2, 1'b1, 0, 1'b1, 1'b0);  // timeout keeps prior result
        rst_abort(k1, m1);
        run_txn(k1, m1, c1, 1'b0, 2, 1'b0, 1'b0);  // fresh start after reset
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_main_node.md
# spi_main_node

Serial initiator that drives the encryption unit's subnode port. It latches a key and a message block, shifts them out on `mosi` under `cs_enc`, waits for the subnode's `data_done`, then shifts the cipher block back in from `miso` and presents it in parallel. It sits on the system side of the encryption unit, sharing that unit's `clk`, and is the host-facing controller for one encryption transaction at a time.

## Interface
- `nk`, default 8: key length in 32-bit words (key width 32*nk).
- `nb`, default 4: block length in 32-bit words (msg and cipher width 32*nb).
- `TIMEOUT`, default 1024: maximum cycles spent in WAIT_DONE before the transaction aborts.

Ports:
- `clk`  in  1: single clock, shared with the encryption unit; all logic rises on `clk`.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `key_in`  in  32*nk: key, latched on accepted `start`.
- `msg_in`  in  32*nb: plaintext block, latched on accepted `start`.
- `mosi`  out  1: serial data to the subnode.
- `cs_enc`  out  1: subnode select, active-low, idle high.
- `miso`  in  1: serial data from the subnode.
- `data_done`  in  1: subnode indicates the cipher is ready to shift out.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse at the end of a transaction.
- `err`  out  1: high together with `done` on timeout; otherwise 0.
- `result`  out  32*nb: last cipher block received; held until the next `done`.

## Operation
- States: IDLE, SEND_KEY, SEND_MSG, WAIT_DONE, RECV, FINISH.
- IDLE: `cs_enc`=1, `mosi`=0. On `start`=1, latch `key_in` and `msg_in` into a shift register of 32*(nk+nb) bits, clear the bit counter, and go to SEND_KEY.
- SEND_KEY: `cs_enc`=0. Each cycle `mosi` = the current MSB of the key field, then shift left. After 32*nk bits, go to SEND_MSG.
- SEND_MSG: same rule for the msg field, 32*nb bits. Then go to WAIT_DONE.
- WAIT_DONE: `cs_enc`=0, `mosi`=0, timeout counter increments each cycle.
  - `data_done`=1 sampled: go to RECV and clear the bit counter.
  - Counter reaches TIMEOUT: go to FINISH with the error flag set.
- RECV: `cs_enc`=0. Each cycle, sample `miso` into the LSB of the receive shift register (MSB-first). After 32*nb samples, go to FINISH.
- FINISH, one cycle:
  - `cs_enc`=1, `done`=1.
  - On success: copy the receive register to `result`, `err`=0.
  - On timeout: leave `result` unchanged, `err`=1.
  - Then go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Counter widths: the bit counter is $clog2(32*nk) bits; the timeout counter is $clog2(TIMEOUT+1) bits. No wrap-around occurs inside a state.
- `data_done` asserted before WAIT_DONE is ignored. Only its value in WAIT_DONE matters.

## Timing
- Reset values: `cs_enc`=1, `mosi`=0, `busy`=0, `done`=0, `err`=0, `result`=0, state IDLE.
- `rst` mid-transaction aborts on the next edge: outputs return to reset values and no `done` is issued.
- `start` accepted at edge T:
  - T+1: `cs_enc`=0, `busy`=1, `mosi`=key bit 32*nk-1.
  - Key bit k appears in cycle T+1+(32*nk-1-k).
  - Msg MSB appears at T+1+32*nk.
  - Last msg bit appears at T+32*(nk+nb).
- `data_done` sampled high at edge D: the first `miso` sample is taken at edge D+1, the last at D+32*nb.
- `done` is high in the cycle after the last sample. `result` is valid in that same cycle. `busy` falls in that same cycle.
- Minimum transaction length, start edge to done cycle: 32*(nk+nb) + 1 (WAIT_DONE) + 32*nb + 1 cycles.
- `start` asserted in the same cycle as `done` is ignored. The earliest accepted `start` is in the cycle after `done`.
- Timeout: `done`=`err`=1 exactly TIMEOUT+1 cycles after entering WAIT_DONE.

## Test plan
- AES-256 vector with a behavioural subnode model:
  - Stimulus: key 000102…1e1f, msg 00112233445566778899aabbccddeeff.
  - Required: the model captures exactly that key then that msg, MSB-first, over 384 cycles.
  - Required: after the model asserts `data_done` and returns 8ea2b7ca516745bfeafc49904b496089, `result` equals it and `done`=1 with `err`=0.
- Cycle check: with `data_done` already high on WAIT_DONE entry, `done` occurs exactly 32*(nk+nb)+32*nb+2 cycles after the start edge (514 for the defaults).
- Timeout:
  - Stimulus: `data_done` held 0, TIMEOUT=16.
  - Required: `done`=`err`=1 exactly 17 cycles after WAIT_DONE entry, `result` keeps its prior value, and `cs_enc` returns to 1.
- `start` pulses during SEND_MSG and RECV have no effect: a single `done` occurs, and the latched key/msg are unchanged even when `key_in` is altered mid-frame.
- `rst` asserted at cycle 100 of SEND_KEY: the next cycle shows `cs_enc`=1, `busy`=0, `mosi`=0 and no `done`. A fresh `start` then completes normally.
- Back-to-back: `start` in the cycle after `done`, using msg ffeeddccbbaa99887766554433221100, produces a second correct `result` (compared against the reference AES model).
